// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, counter width.
package mdu_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational result datapath: 64-bit {HI,LO} image for the launched op, plus divide-by-zero flag.
// Optional madd/msub accumulate path is built only when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div0
);
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a, mag_b, div_b, q_u, r_u, uq, ur;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow corner entirely.
  assign mag_a = a[31] ? (~a + 32'd1) : a;
  assign mag_b = b[31] ? (~b + 32'd1) : b;
  assign div_b = (b == 32'd0) ? 32'd1 : b;
  assign q_u   = (b == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign r_u   = (b == 32'd0) ? 32'd0 : mag_a % mag_b;
  assign uq    = a / div_b;
  assign ur    = a % div_b;

  always_comb begin
    res  = {hi, lo};
    div0 = 1'b0;
    case (op_e'(op))
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        div0 = (b == 32'd0);
        res  = {(a[31] ? (~r_u + 32'd1) : r_u),
                ((a[31] ^ b[31]) ? (~q_u + 32'd1) : q_u)};
      end
      OP_DIVU: begin
        div0 = (b == 32'd0);
        res  = {ur, uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD: res = {hi, lo} + prod_s;
      OP_MSUB: res = {hi, lo} - prod_s;
`endif
      default: res = {hi, lo};
    endcase
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS mult/div unit: owns HI/LO, drives Busy for the hazard unit, aborts on Cancel.
// Define MDU_MADD_EN to enable the madd/msub accumulate ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoWe,
  input  logic        HiLoSel,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt, lat;
  logic [63:0]        pend, calc_res;
  logic               pend_div0, calc_div0;
  logic               op_ok, is_div, start_go, commit;

  mdu_calc u_calc (
    .a(A), .b(B), .op(Op), .hi(HI), .lo(LO),
    .res(calc_res), .div0(calc_div0)
  );

  always_comb begin
    op_ok = 1'b0;
    case (op_e'(Op))
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

  assign is_div   = (Op == OP_DIV) || (Op == OP_DIVU);
  assign lat      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  assign start_go = (state == ST_IDLE) && Start && op_ok && !Cancel;
  assign commit   = (state == ST_RUN) && (cnt == CNT_W'(1)) && !Cancel;
  assign Busy     = (state == ST_RUN);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    if (Cancel)        state_nx = ST_IDLE;
    else if (start_go) state_nx = ST_RUN;
    else if (commit)   state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      pend      <= '0;
      pend_div0 <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else if (Cancel) begin
      cnt <= '0;
    end else if (start_go) begin
      pend      <= calc_res;
      pend_div0 <= calc_div0;
      cnt       <= lat;
    end else if (state == ST_RUN) begin
      cnt <= cnt - 1'b1;
      if (commit && !pend_div0) {HI, LO} <= pend;
    end else if (HiLoWe && !Start) begin
      // Any Start in IDLE, even a no-op launch, suppresses the mthi/mtlo write.
      if (HiLoSel) HI <= A;
      else         LO <= A;
    end
  end

  a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
    (state == ST_RUN && !Cancel) |-> !Start);
  a_no_write_in_run: assert property (@(posedge clk) disable iff (reset)
    (state == ST_RUN && !Cancel) |-> !HiLoWe);
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with a result scoreboard plus corner sequences.
module tb_mult_div_unit;
  logic        clk = 0, reset = 1, Start = 0, HiLoWe = 0, HiLoSel = 0, Cancel = 0;
  logic [2:0]  Op = 0;
  logic [31:0] A = 0, B = 0;
  logic        Busy;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiLoWe(HiLoWe), .HiLoSel(HiLoSel), .Cancel(Cancel),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    bit          keep;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi, lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit we);
    @(negedge clk);
    Start = 1; Op = op; A = a; B = b; HiLoWe = we; HiLoSel = 0;
    @(posedge clk); #1;
    Start = 0; HiLoWe = 0;
  endtask

  task automatic run_vec(input vec_t v, input bit we);
    exp_t e, got;
    int   n;
    e.name = v.name;
    e.hi   = v.keep ? m_hi : v.hi;
    e.lo   = v.keep ? m_lo : v.lo;
    e.lat  = v.lat;
    launch(v.op, v.a, v.b, we);
    sb.push_back(e);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    got = sb.pop_front();
    check({got.name, " busy"}, 64'(n), 64'(got.lat));
    check({got.name, " hilo"}, {HI, LO}, {got.hi, got.lo});
    m_hi = got.hi; m_lo = got.lo;
  endtask

  task automatic write_hilo(input bit sel, input logic [31:0] d);
    @(negedge clk);
    HiLoWe = 1; HiLoSel = sel; A = d;
    @(posedge clk); #1;
    HiLoWe = 0;
    if (sel) m_hi = d; else m_lo = d;
    check(sel ? "mthi" : "mtlo", {HI, LO}, {m_hi, m_lo});
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{"mult -2*3",      3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 0, 5};
    vt[1] = '{"multu max*2",    3'b001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 0, 5};
    vt[2] = '{"mult maxpos^2",  3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 5};
    vt[3] = '{"div -7/2",       3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 10};
    vt[4] = '{"div 7/-2",       3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 10};
    vt[5] = '{"div min/-1",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 10};
    vt[6] = '{"divu 100/7",     3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       0, 10};
    vt[7] = '{"divu max/2",     3'b011, 32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF, 0, 10};
    vt[8] = '{"divu by zero",   3'b011, 32'h1234,     32'd0,        32'd0,        32'd0,        1, 10};

    repeat (2) @(posedge clk);
    #1;
    check("reset state", {31'b0, Busy, HI, LO}, 96'b0);
    @(negedge clk); reset = 0;

    write_hilo(1, 32'h12345678);
    write_hilo(0, 32'hCAFEF00D);

    // Start together with a write strobe: the launch wins and the write is dropped.
    begin
      vec_t v = '{"start beats mtlo", 3'b000, 32'd2, 32'd3, 32'd0, 32'd6, 0, 5};
      run_vec(v, 1);
    end

    foreach (vt[i]) run_vec(vt[i], 0);

    // Cancel on the third busy cycle: no commit, ever.
    launch(3'b000, 32'd7, 32'd7, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); Cancel = 1;
    @(posedge clk); #1; Cancel = 0;
    check("cancel busy", 64'(Busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("cancel hilo", {HI, LO}, {m_hi, m_lo});

    // Cancel alongside Start: the flushed launch never goes busy.
    @(negedge clk); Cancel = 1; Start = 1; Op = 3'b010; A = 32'd9; B = 32'd3;
    @(posedge clk); #1; Cancel = 0; Start = 0;
    check("cancel+start busy", 64'(Busy), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check("cancel+start hilo", {HI, LO}, {m_hi, m_lo});

    launch(3'b110, 32'd5, 32'd5, 0);
    check("op110 noop busy", 64'(Busy), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("op110 noop hilo", {HI, LO}, {m_hi, m_lo});

`ifdef MDU_MADD_EN
    write_hilo(1, 32'h0);
    write_hilo(0, 32'hFFFFFFFF);
    begin
      vec_t v = '{"madd 1*1", 3'b100, 32'd1, 32'd1, 32'd1, 32'd0, 0, 5};
      run_vec(v, 0);
    end
`else
    launch(3'b100, 32'd1, 32'd1, 0);
    check("madd noop busy", 64'(Busy), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("madd noop hilo", {HI, LO}, {m_hi, m_lo});
`endif

    // Reset mid-run with non-zero HI/LO in place.
    write_hilo(1, 32'hA5A5A5A5);
    launch(3'b001, 32'd3, 32'd4, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1;
    #1;
    check("reset mid-run", {31'b0, Busy, HI, LO}, 96'b0);
    @(negedge clk); reset = 0;
    repeat (10) @(posedge clk);
    #1;
    check("after reset no commit", {31'b0, Busy, HI, LO}, 96'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and drives Busy, which the hazard unit consumes to stall mult/div/mthi/mtlo/mfhi/mflo.
- Executes mult, multu, div and divu.
- Services mthi/mtlo writes.
- Aborts in-flight work when the pipeline is flushed by an exception.

Parameters:
MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (1..15).
DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (1..15).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse; launch Op on A/B (instruction in EX is mult/div class)
Op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 msub (100/101 only with macro)
A  input  32  rs operand (post-forwarding)
B  input  32  rt operand (post-forwarding)
HiLoWe  input  1  mthi/mtlo write strobe
HiLoSel  input  1  0 writes LO, 1 writes HI
Cancel  input  1  exception flush; abort in-flight operation
Busy  output  1  operation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, high): HI=0, LO=0, Busy=0, counter=0, state IDLE.
- States: IDLE, RUN.
- IDLE with Start=1 at edge k:
  - Compute the result combinationally from A/B/Op and latch it into pending regs.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- Busy=1 for cycles k+1 .. k+N.
- RUN: counter decrements every edge. At the edge where counter==1, commit pending to HI/LO and return to IDLE.
- HI/LO therefore hold the new value and Busy=0 from cycle k+N+1.
- HI/LO keep their old value throughout RUN (no partial visibility).
- mult: {HI,LO} = signed A * signed B. multu: unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder carrying the sign of A.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0): full latency is still spent; HI/LO unchanged at commit.
- Start while RUN: ignored. The hazard unit guarantees this never occurs; an assertion flags it in simulation.
- HiLoWe in IDLE: the selected register takes A at the next edge.
- HiLoWe in RUN: ignored (hazard stalls prevent it; assertion flags it).
- Start and HiLoWe in the same cycle: Start wins, write dropped.
- Cancel (any state): next edge returns to IDLE with Busy=0; pending result discarded; HI/LO unchanged.
  - Cancel has priority over Start and HiLoWe in the same cycle, so the flushed instruction has no effect.
  - Cancel on the exact commit edge (counter==1) also suppresses the commit.
- Reset mid-RUN: immediate return to reset values; no commit.
- Op 110/111, or 100/101 without the macro: treated as a no-op launch. Busy stays 0 and nothing changes.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Op 100 (madd): {HI,LO} += signed A*B.
  - Op 101 (msub): {HI,LO} -= signed A*B.
  - Both use MULT_CYCLES latency.
  - The accumulate uses HI/LO sampled at Start.
  - 64-bit wraparound, no overflow flag.
- Undefined: 100/101 are no-op launches and the accumulate path is absent from the RTL.

Decomposition:
- Shared package mdu_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB.
  - State encodings: ST_IDLE, ST_RUN.
  - 4-bit counter width constant.
- One sub-module, mdu_calc: purely combinational. Takes A, B, Op, HI, LO and returns the 64-bit pending result plus a div0 flag.
- mult_div_unit keeps the FSM, counter and HI/LO registers.

Test Plan:
- mult with A=0xFFFFFFFE (-2), B=3 at cycle 0:
  - Busy=1 on cycles 1..5.
  - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with B=0 -> HI/LO keep their prior values after 10 busy cycles.
- Cancel and write priority, starting from HI=LO=0:
  - HiLoWe=1, HiLoSel=1, A=0x12345678 -> HI=0x12345678 next cycle.
  - Start mult 7*7, then Cancel on busy cycle 3 -> Busy=0 next cycle, HI/LO unchanged.
  - Cancel together with Start -> no Busy.
- With MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 busy cycles.
- Reset asserted mid-RUN -> HI=LO=0 and Busy=0 at once, with no commit after release.
